keypad_serializer: RTL and testbench



---
 rtl/lock_pkg.sv | 19 +
 rtl/keypad_serializer.sv | 122 ++++++++++++
 tb/tb_keypad_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad entry / serial unlock path.
package lock_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_GAP,
    S_TAIL
  } ser_state_t;

  localparam int LOCK_CODE_W = 4;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keypad_serializer.sv
// Parallel code word to MSB-first ser_val/ser_data stream with
// inter-bit idle gaps, trailing re-arm zeros and synchronous abort.
module keypad_serializer
  import lock_pkg::*;
#(
  parameter int CODE_W    = LOCK_CODE_W,
  parameter int GAP       = 1,
  parameter int TAIL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic              abort,
  output logic              ser_val,
  output logic              ser_data,
  output logic              busy
);

  localparam int CW = $clog2(max3(CODE_W, TAIL_BITS, GAP) + 1);

  ser_state_t        state_q, state_d;
  logic [CODE_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     bits_q, bits_d;
  logic [CW-1:0]     gap_q, gap_d;
  logic [CW-1:0]     tail_q, tail_d;
  logic              val_q, val_d;
  logic              dat_q, dat_d;
  logic              last_bit;

  assign last_bit = (bits_q == CW'(1));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    gap_d   = gap_q;
    tail_d  = tail_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !abort) begin
          sh_d    = in_code;
          bits_d  = CW'(CODE_W);
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        sh_d   = sh_q << 1;
        bits_d = bits_q - CW'(1);
        // Tail count is armed with the last code bit so GAP can
        // tell code, tail and end-of-frame apart by counters alone.
        if (last_bit) tail_d = CW'(TAIL_BITS);
        if (GAP > 0) begin
          gap_d   = CW'(GAP);
          state_d = S_GAP;
        end else if (!last_bit) begin
          state_d = S_BIT;
        end else begin
          state_d = (TAIL_BITS > 0) ? S_TAIL : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q > CW'(1)) begin
          gap_d = gap_q - CW'(1);
        end else begin
          gap_d = '0;
          if (bits_q != '0)      state_d = S_BIT;
          else if (tail_q != '0) state_d = S_TAIL;
          else                   state_d = S_IDLE;
        end
      end
      S_TAIL: begin
        tail_d = tail_q - CW'(1);
        if (GAP > 0) begin
          gap_d   = CW'(GAP);
          state_d = S_GAP;
        end else begin
          state_d = (tail_q > CW'(1)) ? S_TAIL : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      sh_d    = '0;
      bits_d  = '0;
      gap_d   = '0;
      tail_d  = '0;
    end
    // Output flops follow the next state so a strobe lines up
    // with the cycle its BIT/TAIL state is current.
    val_d = (state_d == S_BIT) || (state_d == S_TAIL);
    dat_d = (state_d == S_BIT) && sh_d[CODE_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bits_q  <= '0;
      gap_q   <= '0;
      tail_q  <= '0;
      val_q   <= 1'b0;
      dat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      gap_q   <= gap_d;
      tail_q  <= tail_d;
      val_q   <= val_d;
      dat_q   <= dat_d;
    end
  end

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign busy     = (state_q != S_IDLE);
  assign ser_val  = val_q;
  assign ser_data = dat_q;

endmodule

// File: tb/tb_keypad_serializer.sv
// Directed plus random stimulus on two configurations, compared
// cycle by cycle against an expected-strobe queue per instance.
module tb_keypad_serializer;

  typedef logic [1:0] ent_q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v0 = 0, a0 = 0, v1 = 0, a1 = 0;
  logic [3:0] c0 = '0, c1 = '0;
  logic       r0, sv0, sd0, b0;
  logic       r1, sv1, sd1, b1;

  ent_q_t q0, q1;
  int     passed = 0;
  int     failed = 0;
  int     total  = 0;

  always #5 clk = ~clk;

  keypad_serializer u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_code(c0),
    .in_ready(r0), .abort(a0), .ser_val(sv0),
    .ser_data(sd0), .busy(b0)
  );

  keypad_serializer #(.CODE_W(4), .GAP(0), .TAIL_BITS(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_code(c1),
    .in_ready(r1), .abort(a1), .ser_val(sv1),
    .ser_data(sd1), .busy(b1)
  );

  task automatic chk(string tag, logic obs, logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected cycle-by-cycle {ser_val, ser_data} for one frame.
  task automatic frame(ref ent_q_t q, input logic [3:0] c,
                       input int g, input int t);
    for (int i = 3; i >= 0; i--) begin
      q.push_back({1'b1, c[i]});
      repeat (g) q.push_back(2'b00);
    end
    for (int j = 0; j < t; j++) begin
      q.push_back(2'b10);
      repeat (g) q.push_back(2'b00);
    end
  endtask

  task automatic upd(ref ent_q_t q, input logic v, input logic [3:0] c,
                     input logic a, input int g, input int t);
    if (rst) q.delete();
    else if (q.size() > 0) begin
      if (a) q.delete();
      else void'(q.pop_front());
    end else if (v && !a) frame(q, c, g, t);
  endtask

  task automatic cmp(string tag, ref ent_q_t q, input logic sv,
                     input logic sd, input logic b, input logic r);
    logic [1:0] e;
    e = (q.size() > 0) ? q[0] : 2'b00;
    chk({tag, ".ser_val"}, sv, e[1]);
    chk({tag, ".ser_data"}, sd, e[0]);
    chk({tag, ".busy"}, b, q.size() > 0);
    chk({tag, ".in_ready"}, r, (q.size() == 0) && !rst);
  endtask

  task automatic step();
    @(posedge clk);
    upd(q0, v0, c0, a0, 1, 1);
    upd(q1, v1, c1, a1, 0, 0);
    #1;
    cmp("u0", q0, sv0, sd0, b0, r0);
    cmp("u1", q1, sv1, sd1, b1, r1);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Default frame 1011 on u0; u1 keeps valid high and swaps code.
    v0 = 1; c0 = 4'b1011;
    v1 = 1; c1 = 4'b1011;
    step();
    v0 = 0;
    c1 = 4'b0000;
    repeat (11) step();
    v1 = 0;
    repeat (2) step();

    // Abort during the second bit's gap.
    v0 = 1; c0 = 4'($urandom);
    step();
    v0 = 0;
    repeat (3) step();
    a0 = 1;
    step();
    a0 = 0;
    repeat (2) step();

    // Abort has priority over valid while idle.
    a0 = 1; v0 = 1; c0 = 4'b0110;
    a1 = 1; v1 = 1; c1 = 4'b1001;
    repeat (2) step();
    a0 = 0; a1 = 0;
    step();
    v0 = 0; v1 = 0;
    repeat (12) step();

    for (int n = 0; n < 400; n++) begin
      v0  = 1'($urandom_range(0, 1));
      c0  = 4'($urandom);
      a0  = ($urandom_range(0, 15) == 0);
      v1  = 1'($urandom_range(0, 1));
      c1  = 4'($urandom);
      a1  = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0; v0 = 0; v1 = 0; a0 = 0; a1 = 0;
    repeat (12) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
